peripheral_uart_bus_bridge: RTL and testbench

// - UART-to-peripheral-bus initiator: decodes 8N1 command frames from a host on uart_rxd.
// - Drives per_addr/per_din/per_en/per_we to a peripheral bus target (e.g. the UART peripheral).
// - Returns read data on uart_txd. Bus-initiator end of the per_* interface, used for bring-up and debug.

---
 rtl/peripheral_uart_bus_bridge_if.sv | 12 +
 rtl/peripheral_uart_bus_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_peripheral_uart_bus_bridge.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_uart_bus_bridge_if.sv
// Peripheral bus between the UART bridge (initiator) and a per_* target.
// per_dout is expected to be valid in the same cycle as per_en.
interface peripheral_uart_bus_bridge_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic [15:0] per_dout;
  logic        per_en;
  logic [1:0]  per_we;

  modport master (output per_addr, per_din, per_en, per_we, input per_dout);
  modport slave  (input per_addr, per_din, per_en, per_we, output per_dout);
endinterface

// File: rtl/peripheral_uart_bus_bridge.sv
// UART 8N1 command decoder driving one per_* bus cycle; read data returned on uart_txd.
// per_en 2 mclk after the last byte's stop centre; no backpressure, bytes arriving during a reply are dropped.
module peripheral_uart_bus_bridge #(
  parameter int BAUD_DIV     = 16,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic mclk,
  input  logic puc_rst_n,
  input  logic uart_rxd,
  output logic uart_txd,
  output logic busy,
  output logic frame_err,
  peripheral_uart_bus_bridge_if.master per
);
  localparam int HALF     = BAUD_DIV / 2;
  localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int TW       = $clog2(TO_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_AHI, S_ALO, S_DLO, S_DHI, S_BUS, S_TX_LO, S_TX_HI
  } state_t;

  state_t state, state_nxt;

  logic          rxd_s1, rxd_s2, rxd_d;
  logic          rx_active, rx_vld, rx_bad, rx_fall, rx_tick;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift, rx_byte;

  logic          cmd_wr, cmd_byte, cmd_hi;
  logic [13:0]   addr_sh, addr_sh_nxt, per_addr_q;
  logic [15:0]   din_sh, din_sh_nxt, per_din_q;
  logic [7:0]    rd_hi;
  logic [TW-1:0] to_cnt;
  logic          in_frame, to_hit, err_nxt;

  logic [9:0]    tx_sh;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_nbit;
  logic          tx_busy, tx_done, tx_load;
  logic [7:0]    tx_byte;

  assign rx_fall = ~rx_active & rxd_d & ~rxd_s2;
  assign rx_tick = rx_active &&
                   (rx_cnt == ((rx_bit == 4'd0) ? CW'(HALF - 1) : CW'(BAUD_DIV - 1)));

  // Start is re-checked at half a bit; data/stop are then sampled one bit apart.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      rxd_s1 <= 1'b1; rxd_s2 <= 1'b1; rxd_d <= 1'b1;
      rx_active <= 1'b0; rx_cnt <= '0; rx_bit <= '0;
      rx_shift <= '0; rx_byte <= '0; rx_vld <= 1'b0; rx_bad <= 1'b0;
    end else begin
      rxd_s1 <= uart_rxd;
      rxd_s2 <= rxd_s1;
      rxd_d  <= rxd_s2;
      rx_vld <= 1'b0;
      rx_bad <= 1'b0;
      if (rx_fall) begin
        rx_active <= 1'b1;
        rx_cnt    <= '0;
        rx_bit    <= '0;
      end else if (rx_active) begin
        if (rx_tick) begin
          rx_cnt <= '0;
          rx_bit <= rx_bit + 4'd1;
          if (rx_bit == 4'd0) begin
            if (rxd_s2) rx_active <= 1'b0;
          end else if (rx_bit == 4'd9) begin
            rx_active <= 1'b0;
            if (rxd_s2) begin
              rx_vld  <= 1'b1;
              rx_byte <= rx_shift;
            end else begin
              rx_bad <= 1'b1;
            end
          end else begin
            rx_shift <= {rxd_s2, rx_shift[7:1]};
          end
        end else begin
          rx_cnt <= rx_cnt + CW'(1);
        end
      end
    end
  end

  assign in_frame = (state == S_AHI) || (state == S_ALO) || (state == S_DLO) || (state == S_DHI);
  assign to_hit   = in_frame && (to_cnt == TW'(TO_LIMIT));
  assign tx_done  = tx_busy && (tx_cnt == CW'(BAUD_DIV - 1)) && (tx_nbit == 4'd9);

  always_comb begin
    state_nxt   = state;
    err_nxt     = rx_bad;
    tx_load     = 1'b0;
    tx_byte     = per.per_dout[7:0];
    addr_sh_nxt = addr_sh;
    din_sh_nxt  = din_sh;
    case (state)
      S_IDLE: if (rx_vld) state_nxt = S_AHI;
      S_AHI: if (rx_vld) begin
        state_nxt          = S_ALO;
        addr_sh_nxt[13:8]  = rx_byte[5:0];
      end
      S_ALO: if (rx_vld) begin
        state_nxt         = cmd_wr ? S_DLO : S_BUS;
        addr_sh_nxt[7:0]  = rx_byte;
      end
      S_DLO: if (rx_vld) begin
        state_nxt  = cmd_byte ? S_BUS : S_DHI;
        din_sh_nxt = {rx_byte, rx_byte};
      end
      S_DHI: if (rx_vld) begin
        state_nxt         = S_BUS;
        din_sh_nxt[15:8]  = rx_byte;
      end
      S_BUS: begin
        if (rx_vld) err_nxt = 1'b1;
        if (cmd_wr) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_TX_LO;
          tx_load   = 1'b1;
          if (cmd_byte && cmd_hi) tx_byte = per.per_dout[15:8];
        end
      end
      S_TX_LO: begin
        if (rx_vld) err_nxt = 1'b1;
        if (tx_done) begin
          if (cmd_byte) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_TX_HI;
            tx_load   = 1'b1;
            tx_byte   = rd_hi;
          end
        end
      end
      S_TX_HI: begin
        if (rx_vld) err_nxt = 1'b1;
        if (tx_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (in_frame && (rx_bad || to_hit)) begin
      state_nxt = S_IDLE;
      err_nxt   = 1'b1;
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state <= S_IDLE;
      {cmd_wr, cmd_byte, cmd_hi} <= 3'b000;
      addr_sh <= '0; din_sh <= '0; per_addr_q <= '0; per_din_q <= '0;
      rd_hi <= '0; to_cnt <= '0; frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_err <= err_nxt;
      addr_sh   <= addr_sh_nxt;
      din_sh    <= din_sh_nxt;
      if (state == S_IDLE && rx_vld) {cmd_wr, cmd_byte, cmd_hi} <= rx_byte[7:5];
      // Bus address/data take the shadow values only on entry to BUS, then hold.
      if (state_nxt == S_BUS && state != S_BUS) begin
        per_addr_q <= addr_sh_nxt;
        per_din_q  <= din_sh_nxt;
      end
      if (state == S_BUS) rd_hi <= per.per_dout[15:8];
      if (rx_fall) to_cnt <= '0;
      else if (to_cnt != TW'(TO_LIMIT)) to_cnt <= to_cnt + TW'(1);
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      tx_sh <= '1; tx_cnt <= '0; tx_nbit <= '0; tx_busy <= 1'b0;
    end else if (tx_load) begin
      tx_sh   <= {1'b1, tx_byte, 1'b0};
      tx_cnt  <= '0;
      tx_nbit <= '0;
      tx_busy <= 1'b1;
    end else if (tx_busy) begin
      if (tx_cnt == CW'(BAUD_DIV - 1)) begin
        tx_cnt <= '0;
        tx_sh  <= {1'b1, tx_sh[9:1]};
        if (tx_nbit == 4'd9) tx_busy <= 1'b0;
        else                 tx_nbit <= tx_nbit + 4'd1;
      end else begin
        tx_cnt <= tx_cnt + CW'(1);
      end
    end
  end

  assign uart_txd     = tx_sh[0];
  assign busy         = (state != S_IDLE) | rx_active;
  assign per.per_en   = (state == S_BUS);
  assign per.per_we   = (state != S_BUS || !cmd_wr) ? 2'b00 :
                        !cmd_byte                   ? 2'b11 :
                        cmd_hi                      ? 2'b10 : 2'b01;
  assign per.per_addr = per_addr_q;
  assign per.per_din  = per_din_q;
endmodule

// File: tb/tb_peripheral_uart_bus_bridge.sv
// Scoreboard bench: stimulus pushes expected bus cycles, reply bytes and error pulses;
// independent monitors pop and compare as the bridge produces them.
module tb_peripheral_uart_bus_bridge;
  localparam int BD = 16;

  typedef struct {
    logic [13:0] addr;
    logic [1:0]  we;
    logic [15:0] din;
    logic        chk_din;
  } bus_exp_t;

  logic        mclk = 1'b0;
  logic        puc_rst_n;
  logic        rxd;
  logic        uart_txd, busy, frame_err;
  logic [15:0] dout_drv;

  int checks   = 0;
  int failures = 0;
  int err_seen = 0;
  int err_exp  = 0;

  bus_exp_t    bus_q[$];
  logic [7:0]  tx_q[$];

  peripheral_uart_bus_bridge_if bus ();
  assign bus.per_dout = dout_drv;

  peripheral_uart_bus_bridge #(.BAUD_DIV(BD), .TIMEOUT_BITS(32)) dut (
    .mclk      (mclk),
    .puc_rst_n (puc_rst_n),
    .uart_rxd  (rxd),
    .uart_txd  (uart_txd),
    .busy      (busy),
    .frame_err (frame_err),
    .per       (bus.master)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rxd = 1'b0; tick(BD);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i]; tick(BD);
    end
    rxd = stop_bit; tick(BD);
    rxd = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge mclk);
      n++;
    end
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL busy_timeout actual=busy_high expected=idle_within_3000");
    end
    tick(20);
  endtask

  task automatic push_bus(input logic [13:0] a, input logic [1:0] we, input logic [15:0] d, input logic c);
    bus_exp_t e;
    e.addr = a; e.we = we; e.din = d; e.chk_din = c;
    bus_q.push_back(e);
  endtask

  // Bus monitor
  initial begin
    bus_exp_t e;
    forever begin
      @(negedge mclk);
      if (bus.per_en === 1'b1) begin
        if (bus_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL bus_unexpected actual=addr_0x%0h expected=no_bus_cycle", bus.per_addr);
        end else begin
          e = bus_q.pop_front();
          check("bus_addr", 32'(bus.per_addr), 32'(e.addr));
          check("bus_we", 32'(bus.per_we), 32'(e.we));
          if (e.chk_din) check("bus_din", 32'(bus.per_din), 32'(e.din));
        end
        @(negedge mclk);
        check("per_en_one_cycle", 32'(bus.per_en), 32'd0);
      end
    end
  end

  // TX monitor: decode each frame at bit centres
  initial begin
    logic [7:0] b;
    logic       stp;
    forever begin
      @(negedge mclk);
      if (puc_rst_n === 1'b1 && uart_txd === 1'b0) begin
        repeat (BD / 2) @(negedge mclk);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge mclk);
          b[i] = uart_txd;
        end
        repeat (BD) @(negedge mclk);
        stp = uart_txd;
        check("tx_stop", 32'(stp), 32'd1);
        if (tx_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_unexpected actual=0x%0h expected=no_tx", b);
        end else begin
          check("tx_byte", 32'(b), 32'(tx_q.pop_front()));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge mclk);
      if (frame_err === 1'b1) err_seen++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    puc_rst_n = 1'b0; rxd = 1'b1; dout_drv = 16'h0000;
    tick(5);
    @(negedge mclk);
    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_per_en", 32'(bus.per_en), 32'd0);
    check("rst_per_we", 32'(bus.per_we), 32'd0);
    check("rst_per_addr", 32'(bus.per_addr), 32'd0);
    check("rst_per_din", 32'(bus.per_din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    puc_rst_n = 1'b1;
    tick(20);

    // Word write, no reply
    push_bus(14'h0123, 2'b11, 16'h1234, 1'b1);
    send_byte(8'h80); send_byte(8'h01); send_byte(8'h23); send_byte(8'h34); send_byte(8'h12);
    wait_idle();

    // Word read: lo then hi byte, busy until the last stop bit
    dout_drv = 16'hBEEF;
    push_bus(14'h0010, 2'b00, 16'h0000, 1'b0);
    tx_q.push_back(8'hEF); tx_q.push_back(8'hBE);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    check("rd_busy_during_reply", 32'(busy), 32'd1);
    wait_idle();
    check("rd_reply_done_at_busy_fall", 32'(tx_q.size()), 32'd0);

    // Byte writes, hi and lo lanes
    push_bus(14'h0005, 2'b10, 16'hA5A5, 1'b1);
    send_byte(8'hE0); send_byte(8'h00); send_byte(8'h05); send_byte(8'hA5);
    wait_idle();
    push_bus(14'h0007, 2'b01, 16'h3C3C, 1'b1);
    send_byte(8'hC0); send_byte(8'h00); send_byte(8'h07); send_byte(8'h3C);
    wait_idle();

    // Byte read of hi lane: single reply byte
    dout_drv = 16'h5A00;
    push_bus(14'h0005, 2'b00, 16'h0000, 1'b0);
    tx_q.push_back(8'h5A);
    send_byte(8'h60); send_byte(8'h00); send_byte(8'h05);
    wait_idle();

    // Bad stop bit on CMD, then a normal read
    err_exp++;
    send_byte(8'h80, 1'b0);
    tick(BD * 2);
    dout_drv = 16'hBEEF;
    push_bus(14'h0010, 2'b00, 16'h0000, 1'b0);
    tx_q.push_back(8'hEF); tx_q.push_back(8'hBE);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    wait_idle();

    // Inter-byte timeout: 32 bit-times after the last start edge
    err_exp++;
    send_byte(8'h80); send_byte(8'h00);
    n = 0;
    while (frame_err !== 1'b1 && n < 600) begin
      @(negedge mclk);
      n++;
    end
    check("timeout_latency_in_window", 32'(n >= 346 && n <= 366), 32'd1);
    tick(200);
    check("timeout_back_idle", 32'(busy), 32'd0);

    // Full frame after timeout; CMD[4:0] and AHI[7:6] ignored, max address
    push_bus(14'h3FFF, 2'b11, 16'h0001, 1'b1);
    send_byte(8'h9F); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h01); send_byte(8'h00);
    wait_idle();

    // Reset during ALO of a write
    send_byte(8'h80); send_byte(8'h00);
    rxd = 1'b0; tick(BD);
    rxd = 1'b1; tick(BD * 3);
    puc_rst_n = 1'b0;
    tick(3);
    @(negedge mclk);
    check("midrst_per_en", 32'(bus.per_en), 32'd0);
    check("midrst_per_we", 32'(bus.per_we), 32'd0);
    check("midrst_per_addr", 32'(bus.per_addr), 32'd0);
    check("midrst_per_din", 32'(bus.per_din), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_txd", 32'(uart_txd), 32'd1);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    puc_rst_n = 1'b1;
    tick(BD * 12);
    dout_drv = 16'h1357;
    push_bus(14'h0010, 2'b00, 16'h0000, 1'b0);
    tx_q.push_back(8'h57); tx_q.push_back(8'h13);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    wait_idle();

    // Overrun: a byte arriving during the reply is dropped, reply intact
    dout_drv = 16'hCAFE;
    push_bus(14'h0020, 2'b00, 16'h0000, 1'b0);
    tx_q.push_back(8'hFE); tx_q.push_back(8'hCA);
    err_exp++;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h55);
    wait_idle();
    check("overrun_reply_done", 32'(tx_q.size()), 32'd0);

    // 3-cycle glitch while idle
    rxd = 1'b0; tick(3);
    rxd = 1'b1; tick(BD * 20);
    check("glitch_busy", 32'(busy), 32'd0);

    tick(100);
    check("frame_err_count", 32'(err_seen), 32'(err_exp));
    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    check("tx_q_drained", 32'(tx_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
